// File: rtl/tlm_get_fifo_mc.sv
// ---------------------------------------------------------------------------
// tlm_get_fifo_mc
//
// Multi-channel FIFO with a TLM-style get/peek port. A single producer port
// writes into NCHAN independent circular buffers. A single consumer port
// issues get / try_get / peek / try_peek requests against any channel.
// Responses are registered and arrive one cycle after the request is
// serviced.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   put_valid  producer offers an entry
//   put_chan   target channel of the put
//   put_data   put payload
//   put_ready  target channel not full (from registered count)
//   get_req    consumer issues an operation (ignored while get_busy)
//   get_chan   channel addressed by get_req
//   get_op     00 get, 01 try_get, 10 peek, 11 try_peek
//   get_busy   a blocking request is pending
//   rsp_valid  one-cycle response pulse
//   rsp_ok     1 = rsp_data holds an entry, 0 = try_* failed
//   rsp_data   returned entry (0 when rsp_ok = 0)
//   can_get    bit i = channel i non-empty
//   stat_fail  (only with TLM_GET_FIFO_MC_STATS_EN) 16-bit saturating count
//              of failed try_* responses per channel, field i at [16*i +: 16]
//
// Optional feature macro: TLM_GET_FIFO_MC_STATS_EN
// ---------------------------------------------------------------------------
module tlm_get_fifo_mc #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int NCHAN = 4,
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 put_valid,
  input  logic [CW-1:0]        put_chan,
  input  logic [WIDTH-1:0]     put_data,
  output logic                 put_ready,
  input  logic                 get_req,
  input  logic [CW-1:0]        get_chan,
  input  logic [1:0]           get_op,
  output logic                 get_busy,
  output logic                 rsp_valid,
  output logic                 rsp_ok,
  output logic [WIDTH-1:0]     rsp_data,
  output logic [NCHAN-1:0]     can_get
`ifdef TLM_GET_FIFO_MC_STATS_EN
  ,
  output logic [NCHAN*16-1:0]  stat_fail
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNTW  = $clog2(DEPTH + 1);
  // Storage is sized to every encodable channel index. Slots at or above
  // NCHAN are never written, so their counts stay zero and any request on
  // them behaves as "always empty".
  localparam int NSLOT = 1 << CW;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state;
  logic [CW-1:0]     wait_chan;
  logic [1:0]        wait_op;

  logic [WIDTH-1:0]  mem    [NSLOT][DEPTH];
  logic [AW-1:0]     wr_ptr [NSLOT];
  logic [AW-1:0]     rd_ptr [NSLOT];
  logic [CNTW-1:0]   count  [NSLOT];

  logic [CW-1:0]     sel_chan;
  logic [1:0]        sel_op;
  logic              sel_act;
  logic              sel_avail;
  logic [WIDTH-1:0]  head;
  logic              pop;
  logic              put_fire;
  logic [NSLOT-1:0]  wr_en;
  logic [NSLOT-1:0]  rd_en;

  // In WAIT the latched request is re-evaluated every cycle; in IDLE the
  // live request drives the same path, so both states share one datapath.
  always_comb begin
    sel_chan  = (state == WAIT) ? wait_chan : get_chan;
    sel_op    = (state == WAIT) ? wait_op   : get_op;
    sel_act   = (state == WAIT) || get_req;
    sel_avail = (count[sel_chan] != '0);
    head      = mem[sel_chan][rd_ptr[sel_chan]];
    pop       = sel_act && sel_avail && !sel_op[1];
    put_ready = (int'(put_chan) < NCHAN) && (count[put_chan] != CNTW'(DEPTH));
    put_fire  = put_valid && put_ready;
    for (int i = 0; i < NSLOT; i++) begin
      wr_en[i] = put_fire && (put_chan == CW'(i));
      rd_en[i] = pop && (sel_chan == CW'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NCHAN; i++) begin
      can_get[i] = (count[i] != '0);
    end
  end

  assign get_busy = (state == WAIT);

  // Pointer and occupancy state per channel; a same-cycle put and pop on
  // one channel advances both pointers and leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOT; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (rd_en[i]) rd_ptr[i] <= rd_ptr[i] + AW'(1);
        if (wr_en[i] && !rd_en[i])      count[i] <= count[i] + CNTW'(1);
        else if (rd_en[i] && !wr_en[i]) count[i] <= count[i] - CNTW'(1);
      end
    end
  end

  // Payload storage carries no reset.
  always_ff @(posedge clk) begin
    if (put_fire) mem[put_chan][wr_ptr[put_chan]] <= put_data;
  end

  // Request FSM with registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_chan <= '0;
      wait_op   <= '0;
      rsp_valid <= 1'b0;
      rsp_ok    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_ok    <= 1'b0;
      rsp_data  <= '0;
      case (state)
        IDLE: begin
          if (get_req) begin
            if (sel_avail) begin
              rsp_valid <= 1'b1;
              rsp_ok    <= 1'b1;
              rsp_data  <= head;
            end else if (get_op[0]) begin
              rsp_valid <= 1'b1;
            end else begin
              state     <= WAIT;
              wait_chan <= get_chan;
              wait_op   <= get_op;
            end
          end
        end
        WAIT: begin
          if (sel_avail) begin
            rsp_valid <= 1'b1;
            rsp_ok    <= 1'b1;
            rsp_data  <= head;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TLM_GET_FIFO_MC_STATS_EN
  logic [15:0] fail_cnt [NCHAN];
  logic        fail_evt;

  assign fail_evt = (state == IDLE) && get_req && !sel_avail && get_op[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCHAN; i++) fail_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        if (fail_evt && (get_chan == CW'(i)) && (fail_cnt[i] != 16'hFFFF))
          fail_cnt[i] <= fail_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCHAN; i++) stat_fail[i*16 +: 16] = fail_cnt[i];
  end
`endif

endmodule

// File: tb/tb_tlm_get_fifo_mc.sv
// ---------------------------------------------------------------------------
// Testbench for tlm_get_fifo_mc: directed scenarios followed by random
// traffic, all checked cycle by cycle against a queue-based model.
// ---------------------------------------------------------------------------
module tb_tlm_get_fifo_mc;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int NCHAN = 4;
  localparam int CW    = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               put_valid;
  logic [CW-1:0]      put_chan;
  logic [WIDTH-1:0]   put_data;
  logic               put_ready;
  logic               get_req;
  logic [CW-1:0]      get_chan;
  logic [1:0]         get_op;
  logic               get_busy;
  logic               rsp_valid;
  logic               rsp_ok;
  logic [WIDTH-1:0]   rsp_data;
  logic [NCHAN-1:0]   can_get;
`ifdef TLM_GET_FIFO_MC_STATS_EN
  logic [NCHAN*16-1:0] stat_fail;
`endif

  tlm_get_fifo_mc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCHAN(NCHAN)) dut (
    .clk(clk), .rst_n(rst_n),
    .put_valid(put_valid), .put_chan(put_chan), .put_data(put_data),
    .put_ready(put_ready),
    .get_req(get_req), .get_chan(get_chan), .get_op(get_op),
    .get_busy(get_busy),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_data(rsp_data),
    .can_get(can_get)
`ifdef TLM_GET_FIFO_MC_STATS_EN
    , .stat_fail(stat_fail)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [1:0] OP_GET = 2'b00, OP_TGET = 2'b01,
                         OP_PEEK = 2'b10, OP_TPEEK = 2'b11;

  int tests = 0;
  int fails = 0;

  // Model: one queue per channel plus the pending blocking request.
  logic [WIDTH-1:0] q [NCHAN][$];
  logic             pend = 1'b0;
  int               pch  = 0;
  logic [1:0]       pop_ = 2'b00;
  logic [15:0]      sfail [NCHAN];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCHAN; i++) begin
      q[i].delete();
      sfail[i] = 16'h0;
    end
    pend = 1'b0;
  endtask

  // One clock cycle: drive inputs, check pre-edge status, advance the model,
  // then check the registered response after the edge.
  task automatic step(input logic pv, input logic [CW-1:0] pc, input logic [WIDTH-1:0] pd,
                      input logic rq, input logic [CW-1:0] gc, input logic [1:0] go);
    logic e_pr, ev, eok, act;
    logic [WIDTH-1:0] ed;
    logic [NCHAN-1:0] ecg;
    logic [63:0] es;
    int ch;
    logic [1:0] op;
    put_valid = pv; put_chan = pc; put_data = pd;
    get_req = rq; get_chan = gc; get_op = go;
    #1;
    e_pr = (q[pc].size() < DEPTH);
    for (int i = 0; i < NCHAN; i++) ecg[i] = (q[i].size() != 0);
    chk("put_ready", {63'd0, put_ready}, {63'd0, e_pr});
    chk("can_get", {60'd0, can_get}, {60'd0, ecg});
    chk("get_busy", {63'd0, get_busy}, {63'd0, pend});
    ev = 1'b0; eok = 1'b0; ed = '0;
    act = pend || rq;
    ch  = pend ? pch : int'(gc);
    op  = pend ? pop_ : go;
    if (act) begin
      if (q[ch].size() > 0) begin
        ev = 1'b1; eok = 1'b1; ed = q[ch][0];
        if (!op[1]) void'(q[ch].pop_front());
        pend = 1'b0;
      end else if (!pend && op[0]) begin
        ev = 1'b1;
        if (sfail[ch] != 16'hFFFF) sfail[ch] = sfail[ch] + 16'd1;
      end else if (!pend) begin
        pend = 1'b1; pch = ch; pop_ = op;
      end
    end
    if (pv && e_pr) q[pc].push_back(pd);
    @(posedge clk);
    #1;
    chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, ev});
    chk("rsp_ok", {63'd0, rsp_ok}, {63'd0, eok});
    chk("rsp_data", {32'd0, rsp_data}, {32'd0, ed});
`ifdef TLM_GET_FIFO_MC_STATS_EN
    for (int i = 0; i < NCHAN; i++) es[i*16 +: 16] = sfail[i];
    chk("stat_fail", stat_fail, es);
`else
    es = '0;
`endif
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, OP_GET);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    put_valid = 1'b0; put_chan = '0; put_data = '0;
    get_req = 1'b0; get_chan = '0; get_op = '0;
    model_reset();
    #23;
    chk("rst_put_ready", {63'd0, put_ready}, 64'd1);
    chk("rst_can_get", {60'd0, can_get}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_get_busy", {63'd0, get_busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // ch2: four puts, try_peek, four try_gets, one failing try_get
    for (int i = 0; i < 4; i++) step(1'b1, 2'd2, 32'hA0 + i, 1'b0, '0, OP_GET);
    step(1'b0, '0, '0, 1'b1, 2'd2, OP_TPEEK);
    chk("peek_A0", {32'd0, rsp_data}, 64'hA0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b1, 2'd2, OP_TGET);
      chk("tget_seq", {32'd0, rsp_data}, 64'hA0 + i);
    end
    step(1'b0, '0, '0, 1'b1, 2'd2, OP_TGET);
    chk("tget_empty_ok", {63'd0, rsp_ok}, 64'd0);

    // ch1: fill, refused put, pop with put held, wrap ordering
    for (int i = 0; i < 4; i++) step(1'b1, 2'd1, 32'hB0 + i, 1'b0, '0, OP_GET);
    step(1'b1, 2'd1, 32'hBF, 1'b0, '0, OP_GET);
    step(1'b1, 2'd1, 32'hB4, 1'b1, 2'd1, OP_TGET);
    step(1'b1, 2'd1, 32'hB4, 1'b0, '0, OP_GET);
    for (int i = 1; i < 5; i++) step(1'b0, '0, '0, 1'b1, 2'd1, OP_GET);
    chk("wrap_last", {32'd0, rsp_data}, 64'hB4);

    // blocking get on empty ch3, then put
    step(1'b0, '0, '0, 1'b1, 2'd3, OP_GET);
    idle(3);
    step(1'b1, 2'd3, 32'h55, 1'b0, '0, OP_GET);
    idle(1);
    chk("bget_data", {32'd0, rsp_data}, 64'h55);
    idle(1);

    // blocking peek on ch0, puts to ch1 meanwhile
    step(1'b0, '0, '0, 1'b1, 2'd0, OP_PEEK);
    step(1'b1, 2'd1, 32'h11, 1'b1, 2'd1, OP_TGET);
    step(1'b1, 2'd1, 32'h12, 1'b0, '0, OP_GET);
    step(1'b1, 2'd0, 32'h77, 1'b0, '0, OP_GET);
    idle(1);
    chk("bpeek_data", {32'd0, rsp_data}, 64'h77);
    idle(1);

    // reset while waiting on ch3
    step(1'b0, '0, '0, 1'b1, 2'd3, OP_GET);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rstw_get_busy", {63'd0, get_busy}, 64'd0);
    chk("rstw_can_get", {60'd0, can_get}, 64'd0);
    chk("rstw_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) < 55), CW'($urandom_range(0, NCHAN - 1)), $urandom,
           ($urandom_range(0, 99) < 50), CW'($urandom_range(0, NCHAN - 1)),
           2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
